// File: rtl/hdlc_rx_frame_buffer_pkg.sv
// Shared HDLC constants and read-side state encoding.
package hdlc_pkg;

    localparam logic [15:0] CRC16_INIT         = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_REF     = 16'h8408;
    localparam logic [15:0] CRC16_GOOD_RESIDUE = 16'hF0B8;
    localparam int          HDLC_MIN_FRAME     = 3;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_LOAD   = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_e;

endpackage

// File: rtl/hdlc_rx_frame_buffer_crc.sv
// Byte-wide CRC-16/X.25 next-state function (reflected, LSB first).
module hdlc_crc16_x25
    import hdlc_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    // Eight serial shift steps unrolled into one combinational stage.
    always_comb begin
        c = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY_REF) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/hdlc_rx_frame_buffer.sv
// HDLC receive frame buffer: stores frames, checks and strips the FCS,
// commits good frames, rolls back bad ones and streams payloads out.
//
// Read-side states:
//   state     | meaning
//   RD_IDLE   | waiting for a committed frame length
//   RD_LOAD   | synchronous RAM read of the first payload byte
//   RD_STREAM | output register valid, advancing one byte per handshake
module hdlc_rx_frame_buffer
    import hdlc_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int LEN_DEPTH = 16,
    parameter int MAX_LEN   = 512,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    input  logic [7:0]       s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [7:0]       m_tdata,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] crc_err_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam int AW     = $clog2(DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int LAW    = $clog2(LEN_DEPTH);
    localparam int LPTR_W = LAW + 1;
    localparam int LEN_W  = $clog2(MAX_LEN + 1);

    logic [7:0]       mem    [DEPTH];
    logic [LEN_W-1:0] lf_mem [LEN_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_inc;
    logic [LPTR_W-1:0] lf_wr_ptr_q, lf_wr_ptr_d, lf_rd_ptr_q;
    logic [15:0]       crc_q, crc_d, crc_next;
    logic [LEN_W-1:0]  len_q, len_d, rem_q;
    logic [LEN_W:0]    new_len;
    logic              ovf_q, ovf_d, over, fifo_full, lf_full, lf_empty;
    logic              mem_we, lf_push;
    logic [LEN_W-1:0]  lf_push_len;
    logic [CNT_W-1:0]  good_cnt_q, good_cnt_d, crc_err_cnt_q, crc_err_cnt_d, ovf_cnt_q, ovf_cnt_d;
    rd_state_e         rd_state_q;
    logic              m_tvalid_q, m_tlast_q;
    logic [7:0]        m_tdata_q;

    hdlc_crc16_x25 u_crc (
        .crc_in  (crc_q),
        .data_in (s_tdata),
        .crc_out (crc_next)
    );

    assign new_len    = {1'b0, len_q} + (LEN_W+1)'(1);
    assign over       = new_len > (LEN_W+1)'(MAX_LEN);
    assign fifo_full  = (wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH);
    assign lf_full    = (lf_wr_ptr_q - lf_rd_ptr_q) == LPTR_W'(LEN_DEPTH);
    assign lf_empty   = lf_wr_ptr_q == lf_rd_ptr_q;
    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

    // Write side: accumulate CRC/length, store bytes, decide commit or rollback at end of frame.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        commit_ptr_d  = commit_ptr_q;
        crc_d         = crc_q;
        len_d         = len_q;
        ovf_d         = ovf_q;
        lf_wr_ptr_d   = lf_wr_ptr_q;
        good_cnt_d    = good_cnt_q;
        crc_err_cnt_d = crc_err_cnt_q;
        ovf_cnt_d     = ovf_cnt_q;
        mem_we        = 1'b0;
        lf_push       = 1'b0;
        lf_push_len   = LEN_W'(new_len - (LEN_W+1)'(2));
        if (s_tvalid) begin
            if (s_tlast) begin
                if (ovf_q || over || lf_full) begin
                    wr_ptr_d  = commit_ptr_q;
                    ovf_cnt_d = (ovf_cnt_q == '1) ? ovf_cnt_q : ovf_cnt_q + CNT_W'(1);
                end else if (new_len < (LEN_W+1)'(HDLC_MIN_FRAME) ||
                             crc_next != CRC16_GOOD_RESIDUE) begin
                    wr_ptr_d      = commit_ptr_q;
                    crc_err_cnt_d = (crc_err_cnt_q == '1) ? crc_err_cnt_q
                                                          : crc_err_cnt_q + CNT_W'(1);
                end else begin
                    // The first FCS byte is already in the RAM; step back over it.
                    wr_ptr_d     = wr_ptr_q - PTR_W'(1);
                    commit_ptr_d = wr_ptr_q - PTR_W'(1);
                    lf_push      = 1'b1;
                    lf_wr_ptr_d  = lf_wr_ptr_q + LPTR_W'(1);
                    good_cnt_d   = (good_cnt_q == '1) ? good_cnt_q : good_cnt_q + CNT_W'(1);
                end
                crc_d = CRC16_INIT;
                len_d = '0;
                ovf_d = 1'b0;
            end else begin
                crc_d = crc_next;
                if (!over) begin
                    len_d = new_len[LEN_W-1:0];
                end
                if (ovf_q || over || fifo_full) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    // Write-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            crc_q         <= CRC16_INIT;
            len_q         <= '0;
            ovf_q         <= 1'b0;
            lf_wr_ptr_q   <= '0;
            good_cnt_q    <= '0;
            crc_err_cnt_q <= '0;
            ovf_cnt_q     <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            commit_ptr_q  <= commit_ptr_d;
            crc_q         <= crc_d;
            len_q         <= len_d;
            ovf_q         <= ovf_d;
            lf_wr_ptr_q   <= lf_wr_ptr_d;
            good_cnt_q    <= good_cnt_d;
            crc_err_cnt_q <= crc_err_cnt_d;
            ovf_cnt_q     <= ovf_cnt_d;
        end
    end

    // Data RAM and length FIFO write ports (no reset on storage).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= s_tdata;
        end
        if (lf_push) begin
            lf_mem[lf_wr_ptr_q[LAW-1:0]] <= lf_push_len;
        end
    end

    // Read-side FSM; m_tdata is the synchronous RAM read register, refilled on each handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q  <= RD_IDLE;
            rd_ptr_q    <= '0;
            lf_rd_ptr_q <= '0;
            rem_q       <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tdata_q   <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (!lf_empty) begin
                        rem_q       <= lf_mem[lf_rd_ptr_q[LAW-1:0]];
                        lf_rd_ptr_q <= lf_rd_ptr_q + LPTR_W'(1);
                        rd_state_q  <= RD_LOAD;
                    end
                end
                RD_LOAD: begin
                    m_tdata_q  <= mem[rd_ptr_q[AW-1:0]];
                    m_tvalid_q <= 1'b1;
                    m_tlast_q  <= rem_q == LEN_W'(1);
                    rd_state_q <= RD_STREAM;
                end
                RD_STREAM: begin
                    if (m_tready) begin
                        rd_ptr_q <= rd_ptr_inc;
                        rem_q    <= rem_q - LEN_W'(1);
                        if (m_tlast_q) begin
                            m_tvalid_q <= 1'b0;
                            m_tlast_q  <= 1'b0;
                            rd_state_q <= RD_IDLE;
                        end else begin
                            m_tdata_q <= mem[rd_ptr_inc[AW-1:0]];
                            m_tlast_q <= rem_q == LEN_W'(2);
                        end
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign m_tvalid    = m_tvalid_q;
    assign m_tlast     = m_tlast_q;
    assign m_tdata     = m_tdata_q;
    assign good_cnt    = good_cnt_q;
    assign crc_err_cnt = crc_err_cnt_q;
    assign ovf_cnt     = ovf_cnt_q;

endmodule
